drive_cmd_arbiter: RTL and testbench
====================================

Name: drive_cmd_arbiter

Overview:
- Command sequencer between the UART receiver and the motor PWM/steering stage of the car.
- Decodes byte commands, but only on `rdsig` strobes.
- Selects the steering source: manual UART, line sensors, or vision direction. Enforces a safe steering code.
- Adds a command watchdog that stops the car, plus a rate-limited duty ramp into the PWM generator.

Parameters:
- N, 32, PWM duty width.
- DUTY_H, 32'd1288490188, duty target for 'H'.
- DUTY_L, 32'd2791728742, duty target for 'L'.
- DUTY_M, 32'd2147483648, duty target for 'N'.
- RAMP_STEP, 32'd42949673, maximum duty change per ramp tick.
- RAMP_DIV, 50000, clocks per ramp tick (≥1).
- WDOG_CYCLES, 25000000, clocks without a fresh command before stop (≥2).

Ports:
- clk, input, 1, system clock (single clock domain).
- rst_n, input, 1, asynchronous active-low reset.
- rdsig, input, 1, one-cycle strobe: `data` holds a newly received UART byte.
- data, input, 8, UART received byte.
- sensor_dir, input, 3, line-sensor steering {left, straight, right}.
- vision_dir, input, 3, vision steering {left, straight, right}.
- vision_valid, input, 1, one-cycle strobe: `vision_dir` refreshed.
- left, output, 1, steer-left command.
- stright, output, 1, go-straight command.
- right, output, 1, steer-right command.
- duty, output, N, ramped PWM duty.
- mode, output, 2, 0 = IDLE, 1 = MANUAL, 2 = SENSOR, 3 = VISION.
- fault, output, 1, watchdog expired in the current mode.

Behaviour:
- Reset (async, rst_n = 0): mode = IDLE, left/stright/right = 0, duty = 0, duty target = 0, manual latch = stop, fault = 0, all counters = 0.
- Byte acceptance: a byte is acted on only in a cycle with rdsig = 1. `data` is ignored otherwise. All outputs are registered; an accepted byte at edge t is visible after edge t+1.
- Mode bytes (any mode): 0x31 → MANUAL, 0x32 → SENSOR, 0x33 → VISION.
  - Entering MANUAL, or re-sending 0x31, sets the manual latch to stop.
  - Any mode byte clears fault and restarts the watchdog.
- Steer bytes, MANUAL only: 0x57 'W' → straight, 0x41 'A' → left, 0x44 'D' → right, 0x53 'S' → stop. Ignored in other modes.
- Duty bytes (any mode): 0x48 'H' → target DUTY_H, 0x4C 'L' → target DUTY_L, 0x4E 'N' → target DUTY_M.
- Unknown bytes: no effect on any state.
- Steering output per mode:
  - IDLE: all 0.
  - MANUAL: the manual latch.
  - SENSOR: sensor_dir.
  - VISION: vision_dir, sampled on vision_valid and held between strobes.
- One-hot guard: if the selected source has more than one bit set, outputs are all 0 for that cycle. No priority encoding.
- Watchdog: counter resets on an accepted byte (MANUAL) or a vision_valid strobe (VISION).
  - Counter saturates at WDOG_CYCLES. At saturation, fault = 1 and the steering outputs are forced to 0.
  - The manual latch / held vision value is retained; the next refresh restores it.
  - In IDLE and SENSOR the watchdog is held at 0 and fault = 0.
  - If a refresh and expiry fall in the same cycle, the refresh wins: fault stays 0.
- Mode change: the watchdog clears and fault = 0 in the same edge.
- Duty ramp: a divider counter generates a 1-cycle tick every RAMP_DIV clocks, free-running from reset. On a tick:
  - If |target − duty| ≤ RAMP_STEP, duty = target.
  - Otherwise duty moves RAMP_STEP toward target.
  - Arithmetic is unsigned N-bit. Compare before add/subtract so there is no wrap or overshoot.
  - A target change mid-ramp takes effect at the next tick, from the current duty.
  - fault does not alter the duty ramp; the PWM stage gates motion via the direction bits.
- Reset mid-ramp or mid-timeout: immediate return to reset values.

Test Plan (override RAMP_DIV = 4, RAMP_STEP = 100, WDOG_CYCLES = 20, DUTY_H = 1000):
- Gating: hold data = 0x31 with rdsig = 0 for 10 cycles → mode stays 0. Pulse rdsig 1 cycle → mode = 1 one cycle later; outputs 0 (latch stop).
- Manual steering: in MANUAL send 'A' then 'W' → left = 1 then stright = 1, each 1 cycle after its strobe. 'A' in SENSOR mode → no change.
- Source arbitration: mode 2 with sensor_dir = 3'b010 → stright = 1. sensor_dir = 3'b110 → all 0.
- Vision hold and timeout: mode 3, vision_valid pulse with vision_dir = 3'b001 → right = 1, held. No further strobes for 20 cycles → fault = 1, right = 0. Next strobe → fault = 0, right follows the new value.
- Manual watchdog race: in MANUAL, deliver an accepted byte exactly on the expiry cycle → fault never asserts.
- Duty ramp: send 'H' from duty = 0 → duty 100, 200, …, 1000 at 4-clock intervals, never exceeding 1000. Then 'N' with DUTY_M = 950 → duty = 950 at the next tick (difference ≤ step). Assert rst_n low mid-ramp → duty = 0 immediately.

Source files
------------

// File: rtl/drive_cmd_arbiter.sv
// Command sequencer between the UART receiver and the motor PWM/steering stage:
// byte decode, steering source arbitration, command watchdog and duty ramp.
module drive_cmd_arbiter #(
    parameter int           N           = 32,
    parameter logic [N-1:0] DUTY_H      = N'(32'd1288490188),
    parameter logic [N-1:0] DUTY_L      = N'(32'd2791728742),
    parameter logic [N-1:0] DUTY_M      = N'(32'd2147483648),
    parameter logic [N-1:0] RAMP_STEP   = N'(32'd42949673),
    parameter int           RAMP_DIV    = 50000,
    parameter int           WDOG_CYCLES = 25000000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         rdsig,
    input  logic [7:0]   data,
    input  logic [2:0]   sensor_dir,
    input  logic [2:0]   vision_dir,
    input  logic         vision_valid,
    output logic         left,
    output logic         stright,
    output logic         right,
    output logic [N-1:0] duty,
    output logic [1:0]   mode,
    output logic         fault
);

    localparam logic [1:0] MODE_IDLE   = 2'd0;
    localparam logic [1:0] MODE_MANUAL = 2'd1;
    localparam logic [1:0] MODE_SENSOR = 2'd2;
    localparam logic [1:0] MODE_VISION = 2'd3;

    localparam int             WW       = $clog2(WDOG_CYCLES + 1);
    localparam logic [WW-1:0]  WDOG_MAX = WW'(WDOG_CYCLES);
    localparam logic [WW-1:0]  WDOG_ONE = WW'(1);
    localparam int             DW       = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [DW-1:0]  DIV_LAST = DW'(RAMP_DIV - 1);
    localparam logic [DW-1:0]  DIV_ONE  = DW'(1);

    // Direction codes are {left, straight, right}; more than one bit set is unsafe.
    function automatic logic multi_hot(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

    logic [1:0]    mode_r;
    logic [2:0]    latch_r;
    logic [2:0]    vision_r;
    logic [N-1:0]  target_r;
    logic [N-1:0]  duty_r;
    logic [WW-1:0] wdog_r;
    logic [DW-1:0] div_r;
    logic [1:0]    mode_out_r;
    logic [2:0]    dir_out_r;
    logic          fault_r;

    logic          mode_byte_s;
    logic [1:0]    mode_next_s;
    logic          steer_byte_s;
    logic [2:0]    steer_val_s;
    logic          duty_byte_s;
    logic [N-1:0]  duty_val_s;
    logic          known_s;
    logic          refresh_s;
    logic          expired_s;
    logic [2:0]    sel_s;
    logic [2:0]    dir_next_s;
    logic          tick_s;
    logic [N-1:0]  diff_s;
    logic [N-1:0]  ramp_next_s;

    // Byte decoder: only strobed bytes produce any command.
    always_comb begin
        mode_byte_s  = 1'b0;
        mode_next_s  = MODE_IDLE;
        steer_byte_s = 1'b0;
        steer_val_s  = 3'b000;
        duty_byte_s  = 1'b0;
        duty_val_s   = '0;
        if (rdsig) begin
            case (data)
                8'h31: begin mode_byte_s = 1'b1; mode_next_s = MODE_MANUAL; end
                8'h32: begin mode_byte_s = 1'b1; mode_next_s = MODE_SENSOR; end
                8'h33: begin mode_byte_s = 1'b1; mode_next_s = MODE_VISION; end
                8'h57: begin steer_byte_s = 1'b1; steer_val_s = 3'b010; end
                8'h41: begin steer_byte_s = 1'b1; steer_val_s = 3'b100; end
                8'h44: begin steer_byte_s = 1'b1; steer_val_s = 3'b001; end
                8'h53: begin steer_byte_s = 1'b1; steer_val_s = 3'b000; end
                8'h48: begin duty_byte_s = 1'b1; duty_val_s = DUTY_H; end
                8'h4C: begin duty_byte_s = 1'b1; duty_val_s = DUTY_L; end
                8'h4E: begin duty_byte_s = 1'b1; duty_val_s = DUTY_M; end
                default: begin mode_byte_s = 1'b0; end
            endcase
        end else begin
            mode_byte_s = 1'b0;
        end
        known_s = mode_byte_s | steer_byte_s | duty_byte_s;
    end

    // Watchdog refresh sources; IDLE and SENSOR keep the counter pinned at zero.
    always_comb begin
        case (mode_r)
            MODE_MANUAL: refresh_s = known_s;
            MODE_VISION: refresh_s = mode_byte_s | vision_valid;
            default:     refresh_s = 1'b1;
        endcase
    end

    // Steering source selection with the watchdog and one-hot safety guard.
    always_comb begin
        case (mode_r)
            MODE_MANUAL: sel_s = latch_r;
            MODE_SENSOR: sel_s = sensor_dir;
            MODE_VISION: sel_s = vision_r;
            default:     sel_s = 3'b000;
        endcase
        expired_s = ((mode_r == MODE_MANUAL) || (mode_r == MODE_VISION)) && (wdog_r == WDOG_MAX);
        if (expired_s || multi_hot(sel_s)) begin
            dir_next_s = 3'b000;
        end else begin
            dir_next_s = sel_s;
        end
    end

    // Ramp step: compare the distance first so the add/subtract can never wrap or overshoot.
    always_comb begin
        tick_s = (div_r == DIV_LAST);
        if (target_r >= duty_r) begin
            diff_s = target_r - duty_r;
        end else begin
            diff_s = duty_r - target_r;
        end
        if (diff_s <= RAMP_STEP) begin
            ramp_next_s = target_r;
        end else if (target_r > duty_r) begin
            ramp_next_s = duty_r + RAMP_STEP;
        end else begin
            ramp_next_s = duty_r - RAMP_STEP;
        end
    end

    // Command state: mode, manual latch, duty target, held vision direction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_r   <= MODE_IDLE;
            latch_r  <= 3'b000;
            target_r <= '0;
            vision_r <= 3'b000;
        end else begin
            if (mode_byte_s) begin
                mode_r <= mode_next_s;
            end
            if (mode_byte_s && (mode_next_s == MODE_MANUAL)) begin
                latch_r <= 3'b000;
            end else if (steer_byte_s && (mode_r == MODE_MANUAL)) begin
                latch_r <= steer_val_s;
            end
            if (duty_byte_s) begin
                target_r <= duty_val_s;
            end
            if (vision_valid) begin
                vision_r <= vision_dir;
            end
        end
    end

    // Saturating watchdog; a refresh on the expiry edge wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_r <= '0;
        end else if (refresh_s) begin
            wdog_r <= '0;
        end else if (wdog_r != WDOG_MAX) begin
            wdog_r <= wdog_r + WDOG_ONE;
        end
    end

    // Free-running tick divider and rate-limited duty register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_r  <= '0;
            duty_r <= '0;
        end else begin
            div_r <= tick_s ? '0 : div_r + DIV_ONE;
            if (tick_s) begin
                duty_r <= ramp_next_s;
            end
        end
    end

    // Registered status and steering outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_out_r <= MODE_IDLE;
            dir_out_r  <= 3'b000;
            fault_r    <= 1'b0;
        end else begin
            mode_out_r <= mode_r;
            dir_out_r  <= dir_next_s;
            fault_r    <= expired_s;
        end
    end

    assign left    = dir_out_r[2];
    assign stright = dir_out_r[1];
    assign right   = dir_out_r[0];
    assign duty    = duty_r;
    assign mode    = mode_out_r;
    assign fault   = fault_r;

endmodule

// File: tb/tb_drive_cmd_arbiter.sv
// Randomized and directed bench for drive_cmd_arbiter against a time-based reference model.
module tb_drive_cmd_arbiter;

    localparam int          RAMP_DIV  = 4;
    localparam int          WDOG      = 20;
    localparam longint      STEP      = 100;
    localparam logic [31:0] DUTY_H    = 32'd1000;
    localparam logic [31:0] DUTY_L    = 32'd300;
    localparam logic [31:0] DUTY_M    = 32'd950;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rdsig = 1'b0;
    logic [7:0]  data = 8'h00;
    logic [2:0]  sensor_dir = 3'b000;
    logic [2:0]  vision_dir = 3'b000;
    logic        vision_valid = 1'b0;
    logic        left, stright, right, fault;
    logic [31:0] duty;
    logic [1:0]  mode;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: mode/latch/vision as plain values; watchdog as time since last refresh.
    int     e;
    int     m_mode, m_latch, m_vis, m_last;
    longint m_target, m_duty;
    logic [1:0]  x_mode;
    logic [2:0]  x_dir;
    logic        x_fault;
    logic [31:0] x_duty;
    logic        fault_seen;

    drive_cmd_arbiter #(
        .N(32), .DUTY_H(DUTY_H), .DUTY_L(DUTY_L), .DUTY_M(DUTY_M),
        .RAMP_STEP(32'd100), .RAMP_DIV(RAMP_DIV), .WDOG_CYCLES(WDOG)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rdsig(rdsig), .data(data),
        .sensor_dir(sensor_dir), .vision_dir(vision_dir), .vision_valid(vision_valid),
        .left(left), .stright(stright), .right(right),
        .duty(duty), .mode(mode), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        e = 0; m_mode = 0; m_latch = 0; m_vis = 0; m_last = 0;
        m_target = 0; m_duty = 0;
        x_mode = 2'd0; x_dir = 3'b000; x_fault = 1'b0; x_duty = 32'd0;
    endtask

    // One clock edge of the specified behaviour, using inputs as presented before the edge.
    task automatic model_edge();
        int sel, pre;
        bit expired;
        e++;
        pre = m_mode;
        case (m_mode)
            1: sel = m_latch;
            2: sel = int'(sensor_dir);
            3: sel = m_vis;
            default: sel = 0;
        endcase
        expired = (m_mode == 1 || m_mode == 3) && ((e - 1 - m_last) >= WDOG);
        x_mode  = 2'(m_mode);
        x_fault = expired;
        x_dir   = (expired || $countones(sel) > 1) ? 3'b000 : 3'(sel);
        if (e % RAMP_DIV == 0) begin
            if (m_target >= m_duty)
                m_duty = (m_target - m_duty <= STEP) ? m_target : m_duty + STEP;
            else
                m_duty = (m_duty - m_target <= STEP) ? m_target : m_duty - STEP;
        end
        if (rdsig) begin
            case (data)
                8'h31, 8'h32, 8'h33: begin
                    m_mode = int'(data) - 8'h30;
                    if (data == 8'h31) m_latch = 0;
                    m_last = e;
                end
                8'h57, 8'h41, 8'h44, 8'h53: if (pre == 1) begin
                    m_latch = (data == 8'h57) ? 2 : (data == 8'h41) ? 4 : (data == 8'h44) ? 1 : 0;
                    m_last = e;
                end
                8'h48, 8'h4C, 8'h4E: begin
                    m_target = (data == 8'h48) ? DUTY_H : (data == 8'h4C) ? DUTY_L : DUTY_M;
                    if (pre == 1) m_last = e;
                end
                default: ;
            endcase
        end
        if (vision_valid) begin
            m_vis = int'(vision_dir);
            if (pre == 3) m_last = e;
        end
        if (m_mode == 0 || m_mode == 2) m_last = e;
        x_duty = 32'(m_duty);
    endtask

    // Advance one clock; compare every output with the model on the falling edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("mode", mode, x_mode);
        check("dir", {left, stright, right}, x_dir);
        check("fault", fault, x_fault);
        check("duty", duty, x_duty);
        fault_seen |= fault;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rdsig = 1'b1;
        data  = b;
        step();
        rdsig = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_duty", duty, 32'd0);
        check("rst_mode", mode, 2'd0);
        check("rst_dir", {left, stright, right}, 3'b000);
        check("rst_fault", fault, 1'b0);
        repeat (2) @(negedge clk);
        rdsig = 1'b0; vision_valid = 1'b0; data = 8'h00;
        model_reset();
        rst_n = 1'b1;
    endtask

    function automatic logic [7:0] pick_byte();
        logic [7:0] tbl [10] = '{8'h31, 8'h32, 8'h33, 8'h57, 8'h41, 8'h44, 8'h53, 8'h48, 8'h4C, 8'h4E};
        int k;
        k = $urandom_range(0, 11);
        if (k < 10) return tbl[k];
        return 8'($urandom_range(0, 255));
    endfunction

    initial begin
        longint last;
        rst_n = 1'b1;
        #2;
        do_reset();

        // Bytes without rdsig are ignored.
        data = 8'h31;
        repeat (10) step();
        check("gate_mode", mode, 2'd0);
        send_byte(8'h31);
        step();
        check("gate_mode_after", mode, 2'd1);
        check("gate_dir_stop", {left, stright, right}, 3'b000);

        send_byte(8'h41);
        step();
        check("manual_left", {left, stright, right}, 3'b100);
        send_byte(8'h57);
        step();
        check("manual_straight", {left, stright, right}, 3'b010);

        sensor_dir = 3'b010;
        send_byte(8'h32);
        step();
        check("sensor_mode", mode, 2'd2);
        check("sensor_straight", {left, stright, right}, 3'b010);
        send_byte(8'h41);
        step();
        check("sensor_ignores_A", {left, stright, right}, 3'b010);
        sensor_dir = 3'b110;
        step();
        check("sensor_multihot", {left, stright, right}, 3'b000);

        send_byte(8'h33);
        vision_dir = 3'b001;
        vision_valid = 1'b1;
        step();
        vision_valid = 1'b0;
        vision_dir = 3'b010;
        step();
        check("vision_right", {left, stright, right}, 3'b001);
        repeat (19) step();
        check("vision_pre_timeout", fault, 1'b0);
        check("vision_still_right", right, 1'b1);
        step();
        check("vision_timeout", fault, 1'b1);
        check("vision_forced_off", {left, stright, right}, 3'b000);
        vision_dir = 3'b100;
        vision_valid = 1'b1;
        step();
        vision_valid = 1'b0;
        step();
        check("vision_recover_fault", fault, 1'b0);
        check("vision_recover_dir", {left, stright, right}, 3'b100);

        // Refresh lands exactly on the expiry edge each time.
        send_byte(8'h31);
        fault_seen = 1'b0;
        for (int k = 0; k < 3; k++) begin
            repeat (19) step();
            send_byte(8'h44);
        end
        step();
        check("race_no_fault", fault_seen, 1'b0);
        check("race_right", {left, stright, right}, 3'b001);

        do_reset();
        send_byte(8'h48);
        last = 0;
        for (int i = 0; i < 60 && last != 1000; i++) begin
            step();
            check("ramp_cap", (duty > 32'd1000), 1'b0);
            if (duty != 32'(last)) begin
                check("ramp_increment", duty, last + 100);
                last = duty;
            end
        end
        check("ramp_reached_H", duty, 32'd1000);
        repeat (5) step();
        check("ramp_hold_H", duty, 32'd1000);
        send_byte(8'h4E);
        for (int i = 0; i < 8 && duty == 32'd1000; i++) step();
        check("ramp_snap_M", duty, 32'd950);
        send_byte(8'h4C);
        repeat (6) step();
        check("ramp_down_mid", (duty < 32'd950 && duty > 32'd300), 1'b1);
        do_reset();

        for (int blk = 0; blk < 10; blk++) begin
            int pct, vpct;
            pct  = (blk % 2 == 1) ? 30 : 3;
            vpct = (blk % 2 == 1) ? 8 : 4;
            if (blk == 6) do_reset();
            for (int c = 0; c < 200; c++) begin
                rdsig        = ($urandom_range(0, 99) < pct);
                data         = pick_byte();
                vision_valid = ($urandom_range(0, 99) < vpct);
                vision_dir   = 3'($urandom_range(0, 7));
                sensor_dir   = 3'($urandom_range(0, 7));
                step();
            end
        end
        rdsig = 1'b0;
        vision_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
